// File: rtl/ser2par_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel converter.
package ser2par_pkg;

    // Two-state control: assembling bits, or holding a finished word
    // until the output register frees up.
    typedef enum logic {
        COLLECT = 1'b0,
        PEND    = 1'b1
    } state_e;

    // Width of the valid-bit count field (must represent 1..width).
    function automatic int nbw_f(input int width);
        return $clog2(width + 1);
    endfunction

    // Width of the bit-position counter (0..width-1).
    function automatic int cw_f(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser2par_bitcnt.sv
// Bit-position counter for word assembly: counts accepted bits of the
// current word and flags the final position.
module ser2par_bitcnt
    import ser2par_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cw_f(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          at_last_o
);

    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment; wrap after the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST_POS) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign at_last_o = (cnt_q == LAST_POS);

endmodule

// File: rtl/ser2par.sv
// Serial-to-parallel converter: packs a 1-bit valid/ready stream into
// WIDTH-bit words, with early flush on din_last and a one-word pending
// buffer so input keeps flowing while the downstream is briefly stalled.
module ser2par
    import ser2par_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int LSB_FIRST = 1,
    localparam int NBW       = nbw_f(WIDTH),
    localparam int CW        = cw_f(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             din_last,
    output logic             dout_rdy,
    output logic [WIDTH-1:0] dout,
    output logic [NBW-1:0]   dout_nbits,
    output logic             dout_last,
    output logic             dout_vld,
    input  logic             din_rdy
);

    localparam logic [CW-1:0] TOP_IDX = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [NBW-1:0]   hold_nbits_q, hold_nbits_d;
    logic             hold_last_q, hold_last_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [NBW-1:0]   nbits_q, nbits_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;

    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             cnt_inc;
    logic             cnt_clr;

    logic             acc;
    logic             xfer;
    logic             slot_free;
    logic             complete;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] sh_ins;
    logic [NBW-1:0]   cur_nbits;

    ser2par_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk      (clk),
        .rst_i    (rst),
        .inc_i    (cnt_inc),
        .clr_i    (cnt_clr),
        .cnt_o    (cnt),
        .at_last_o(at_last)
    );

    assign acc       = din_vld & dout_rdy;
    assign xfer      = vld_q & din_rdy;
    assign slot_free = ~vld_q | din_rdy;
    assign complete  = acc & (at_last | din_last);
    assign cur_nbits = NBW'(cnt) + NBW'(1);
    assign idx       = (LSB_FIRST != 0) ? cnt : TOP_IDX - cnt;

    // Assembly register with the incoming bit merged at its position.
    always_comb begin
        sh_ins      = sh_q;
        sh_ins[idx] = din;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: park a finished word when the output slot is busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (complete && !slot_free) state_d = PEND;
            PEND:    if (slot_free)              state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Upstream ready comes from registered state only (no din_vld path).
    always_comb begin
        dout_rdy = ~rst & (state_q == COLLECT);
    end

    // Datapath next values: assembly, pending hold and output register.
    always_comb begin
        sh_d         = sh_q;
        hold_nbits_d = hold_nbits_q;
        hold_last_d  = hold_last_q;
        dout_d       = dout_q;
        nbits_d      = nbits_q;
        last_d       = last_q;
        vld_d        = vld_q;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;

        if (xfer) begin
            vld_d = 1'b0;
        end

        if (state_q == COLLECT) begin
            if (complete) begin
                cnt_clr = 1'b1;
                if (slot_free) begin
                    dout_d  = sh_ins;
                    nbits_d = cur_nbits;
                    last_d  = din_last;
                    vld_d   = 1'b1;
                    sh_d    = '0;
                end else begin
                    sh_d         = sh_ins;
                    hold_nbits_d = cur_nbits;
                    hold_last_d  = din_last;
                end
            end else if (acc) begin
                sh_d    = sh_ins;
                cnt_inc = 1'b1;
            end
        end else if (slot_free) begin
            dout_d  = sh_q;
            nbits_d = hold_nbits_q;
            last_d  = hold_last_q;
            vld_d   = 1'b1;
            sh_d    = '0;
            cnt_clr = 1'b1;
        end
    end

    // Datapath registers; reset discards any partial or held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q         <= '0;
            hold_nbits_q <= '0;
            hold_last_q  <= 1'b0;
            dout_q       <= '0;
            nbits_q      <= '0;
            last_q       <= 1'b0;
            vld_q        <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            hold_nbits_q <= hold_nbits_d;
            hold_last_q  <= hold_last_d;
            dout_q       <= dout_d;
            nbits_q      <= nbits_d;
            last_q       <= last_d;
            vld_q        <= vld_d;
        end
    end

    assign dout       = dout_q;
    assign dout_nbits = nbits_q;
    assign dout_last  = last_q;
    assign dout_vld   = vld_q;

endmodule

// File: tb/tb_ser2par.sv
// Bench for ser2par: two instances (LSB-first and MSB-first) share one
// input stream and are compared against a word-level model.
module tb_ser2par;

    localparam int W   = 8;
    localparam int NBW = $clog2(W + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           din, din_vld, din_last, din_rdy;
    logic           rdy_l, rdy_m;
    logic [W-1:0]   dout_l, dout_m;
    logic [NBW-1:0] nb_l, nb_m;
    logic           last_l, last_m, vld_l, vld_m;

    always #5 clk = ~clk;

    ser2par #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_last(din_last),
        .dout_rdy(rdy_l), .dout(dout_l), .dout_nbits(nb_l), .dout_last(last_l),
        .dout_vld(vld_l), .din_rdy(din_rdy)
    );

    ser2par #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_last(din_last),
        .dout_rdy(rdy_m), .dout(dout_m), .dout_nbits(nb_m), .dout_last(last_m),
        .dout_vld(vld_m), .din_rdy(din_rdy)
    );

    typedef struct {
        logic [W-1:0] wl;
        logic [W-1:0] wm;
        int           nb;
        logic         last;
    } item_t;

    // Model: bits of the word in progress, finished words not yet taken
    // downstream, and the word still shown once the output has drained.
    logic  cur_bits[$];
    item_t outq[$];
    item_t held;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic item_t build_word(input logic last);
        item_t it;
        int n;
        n = cur_bits.size();
        it.wl = '0;
        it.wm = '0;
        for (int i = 0; i < n; i++) begin
            it.wl = it.wl | (W'(cur_bits[i]) << i);
            it.wm = it.wm | (W'(cur_bits[i]) << (W - 1 - i));
        end
        it.nb   = n;
        it.last = last;
        return it;
    endfunction

    // One clock cycle: apply inputs, compare outputs, advance the model.
    task automatic step(input logic b, input logic v, input logic l, input logic dr, input logic r);
        item_t disp;
        logic  exp_vld, exp_rdy, a, t;
        @(negedge clk);
        din = b; din_vld = v; din_last = l; din_rdy = dr; rst = r;
        #1;
        exp_vld = (outq.size() != 0);
        exp_rdy = !r && (outq.size() < 2);
        disp    = exp_vld ? outq[0] : held;

        check_eq("rdy_lsb",   32'(rdy_l),  32'(exp_rdy));
        check_eq("rdy_msb",   32'(rdy_m),  32'(exp_rdy));
        check_eq("vld_lsb",   32'(vld_l),  32'(exp_vld));
        check_eq("vld_msb",   32'(vld_m),  32'(exp_vld));
        check_eq("dout_lsb",  32'(dout_l), 32'(disp.wl));
        check_eq("dout_msb",  32'(dout_m), 32'(disp.wm));
        check_eq("nbits_lsb", 32'(nb_l),   32'(disp.nb));
        check_eq("nbits_msb", 32'(nb_m),   32'(disp.nb));
        check_eq("last_lsb",  32'(last_l), 32'(disp.last));
        check_eq("last_msb",  32'(last_m), 32'(disp.last));

        if (r) begin
            cur_bits.delete();
            outq.delete();
            held = '{wl: '0, wm: '0, nb: 0, last: 1'b0};
        end else begin
            a = v && exp_rdy;
            t = exp_vld && dr;
            if (t) begin
                $display("xfer lsb=%h msb=%h nbits=%0d last=%0b", dout_l, dout_m, nb_l, last_l);
                held = outq.pop_front();
            end
            if (a) begin
                cur_bits.push_back(b);
                if (l || cur_bits.size() == W) begin
                    outq.push_back(build_word(l));
                    cur_bits.delete();
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic feed_byte(input logic [W-1:0] bits_seq, input logic dr);
        // bits_seq[W-1] is sent first
        for (int i = W - 1; i >= 0; i--) step(bits_seq[i], 1'b1, 1'b0, dr, 1'b0);
    endtask

    int pulses;
    int drops;

    initial begin
        held = '{wl: '0, wm: '0, nb: 0, last: 1'b0};
        rst = 1'b1; din = 1'b0; din_vld = 1'b0; din_last = 1'b0; din_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, with rst still high
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Full word 1,0,1,1,0,0,0,1
        feed_byte(8'b1011_0001, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("dir_8d_lsb", 32'(dout_l), 32'h8D);
        check_eq("dir_b1_msb", 32'(dout_m), 32'hB1);
        check_eq("dir_nbits8", 32'(nb_l),   32'd8);
        check_eq("dir_vld",    32'(vld_l),  32'd1);
        idle(2);

        // Flushed 3-bit word, then a normal word
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("flush_07",    32'(dout_l), 32'h07);
        check_eq("flush_nbits", 32'(nb_l),   32'd3);
        check_eq("flush_last",  32'(last_l), 32'd1);
        feed_byte(8'h5A, 1'b1);
        idle(2);

        // Flush on the first bit and on the final position
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < W; i++) step(i[0], 1'b1, (i == W - 1), 1'b1, 1'b0);
        idle(2);

        // Downstream stall across two full words
        feed_byte(8'hFF, 1'b0);
        feed_byte(8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pend_rdy", 32'(rdy_l), 32'd0);
        check_eq("pend_out", 32'(dout_l), 32'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pend_second", 32'(dout_l), 32'h00);
        check_eq("pend_rdy_back", 32'(rdy_l), 32'd1);
        idle(2);

        // Four back-to-back words with the downstream always ready
        pulses = 0;
        drops  = 0;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < W; i++) begin
                step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0);
                if (vld_l) pulses++;
                if (!rdy_l) drops++;
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (vld_l) pulses++;
        check_eq("cont_pulses", 32'(pulses), 32'd4);
        check_eq("cont_drops",  32'(drops),  32'd0);
        idle(2);

        // Reset after 5 bits, then a clean word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        feed_byte(8'h3C, 1'b1);
        idle(2);

        // Reset while a word is pending
        feed_byte(8'hA5, 1'b0);
        feed_byte(8'h96, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        feed_byte(8'hC3, 1'b1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 499) == 0));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser2par.md
# ser2par

Serial-to-parallel converter with valid/ready handshakes on both sides. It is the receive-side counterpart of the OFDM parallel-to-serial stage: it packs a 1-bit stream into WIDTH-bit words. A partial word can be flushed early with `din_last`. A one-word pending buffer lets the block keep accepting bits while the downstream is stalled, until a second word completes.

## Interface
- `WIDTH`, default 8: output word width, ≥ 2.
- `LSB_FIRST`, default 1: 1 = first received bit lands in bit 0; 0 = first bit lands in bit WIDTH-1.
- `clk`  in  1  clock; one clock domain; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  1  serial data bit.
- `din_vld`  in  1  upstream: `din`/`din_last` valid.
- `din_last`  in  1  upstream: this bit ends the word (flush).
- `dout_rdy`  out  1  upstream: block can accept a bit.
- `dout`  out  WIDTH  assembled word.
- `dout_nbits`  out  $clog2(WIDTH+1)  number of valid bits in `dout`, 1..WIDTH.
- `dout_last`  out  1  word was closed by `din_last`.
- `dout_vld`  out  1  downstream: `dout`/`dout_nbits`/`dout_last` valid.
- `din_rdy`  in  1  downstream ready.

## Operation
- Accept event A = `din_vld & dout_rdy`. Output transfer T = `dout_vld & din_rdy`. Slot free F = `~dout_vld | din_rdy`.
- Assembly register `sh` (WIDTH bits) and bit counter `cnt` (0..WIDTH-1):
  - On A, the bit is written at index `cnt` if LSB_FIRST=1, else at index WIDTH-1-`cnt`.
  - `cnt` increments on A.
- Completion C = A & (`cnt`==WIDTH-1 | `din_last`).
- States:
  - COLLECT (reset state): `dout_rdy`=1.
    - C & F: word loads into the output register; `sh` clears to 0; `cnt`←0; stay in COLLECT.
    - C & ~F: go to PEND; `sh` and the word's bit count are held.
  - PEND: `dout_rdy`=0.
    - On F: load the held word into the output; `sh`←0; `cnt`←0; go to COLLECT.
- Output register load:
  - `dout`←completed word. Unfilled positions are 0: high bits when LSB_FIRST=1, low bits otherwise.
  - `dout_nbits`←`cnt`+1 (or the held count in PEND).
  - `dout_last`←`din_last` of the closing bit.
  - `dout_vld`←1.
- T without a same-cycle load: `dout_vld`←0; `dout`, `dout_nbits`, `dout_last` hold.
- `din_last` with `cnt`==WIDTH-1: treated as a full word with `dout_last`=1 and `dout_nbits`=WIDTH.
- `din_last` on the first bit of a word: 1-bit word, `dout_nbits`=1.
- `dout_rdy` = ~`rst` & (state==COLLECT). It depends on registered state only; there is no combinational path from `din_vld` or `din_last`.
- Inputs `din`/`din_last` are ignored when A=0.

## Timing
- Reset values: `dout`=0, `dout_nbits`=0, `dout_last`=0, `dout_vld`=0, state COLLECT, `cnt`=0, `sh`=0. `dout_rdy`=0 while `rst`=1.
- Latency: closing bit accepted in cycle N → `dout_vld`=1 in cycle N+1 when F held in cycle N.
- Throughput: one full word per WIDTH cycles with `din_vld` and `din_rdy` held high; no bubbles on either side.
- Simultaneous T and load in the same cycle: new word replaces the old one; `dout_vld` stays 1.
- Downstream stall:
  - Bits are accepted until the next word completes.
  - The cycle after that, `dout_rdy`=0 (PEND).
  - `dout_rdy` returns to 1 the cycle after the first F in PEND.
- Output holds stable while `dout_vld`=1 & `din_rdy`=0.
- Reset mid-word or in PEND: the partial or held word is discarded; there is no output for it.

## Structure
- Shared package: state enum {COLLECT, PEND}, `NBW = $clog2(WIDTH+1)`, `CW = $clog2(WIDTH)`.
- One sub-module, `ser2par_bitcnt`:
  - Counter with synchronous reset, `inc` and `clr` inputs, and a `at_last` (`cnt`==WIDTH-1) output.
  - The FSM, assembly register and output register live in `ser2par`.

## Test plan
- WIDTH=8, LSB_FIRST=1, bits 1,0,1,1,0,0,0,1 back-to-back with `din_rdy`=1 → `dout`=8'h8D, `dout_nbits`=8, `dout_last`=0, `dout_vld` one cycle after the 8th bit.
- Same bits, LSB_FIRST=0 → `dout`=8'hB1.
- LSB_FIRST=1, bits 1,1,1 with `din_last` on the 3rd → `dout`=8'h07, `dout_nbits`=3, `dout_last`=1; the next word starts at `cnt`=0.
- `din_rdy`=0 during two full words (0xFF then 0x00):
  - First word is held on the output.
  - Second word is accepted; `dout_rdy`=0 the cycle after its 8th bit.
  - Raising `din_rdy` delivers 0xFF then 0x00 in consecutive cycles; `dout_rdy` returns to 1.
- Continuous 4 words with `din_rdy`=1 → `dout_rdy` never drops; exactly 4 `dout_vld` pulses, 8 cycles apart.
- `rst` asserted after 5 bits and in PEND → no `dout_vld`, all outputs 0. The first post-reset word is correct.
